// File: rtl/serializador_paridade.sv
// serializador_paridade: parallel-to-serial frame controller with parity.
// Accepts a LARGURA-bit word over valid/ready, shifts it out LSB-first one
// bit per clock, then appends a parity bit computed as a running XOR.
// Optional macro PARIDADE_IMPAR_EN: when defined the parity bit is odd
// (inverted accumulator); when undefined it is even.
module serializador_paridade #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] dado_in,
  input  logic               valido_in,
  output logic               pronto_out,
  output logic               bit_out,
  output logic               bit_valido,
  output logic               eh_paridade
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DADOS    = 2'd1,
    PARIDADE = 2'd2
  } estado_t;

  estado_t            estado;
  logic [LARGURA-1:0] desloc;
  logic [CW-1:0]      contador;
  logic               acc;

  logic               aceita;
  logic [LARGURA-1:0] desloc_prox;
  logic               bit_par;

  // Ready is a pure decode of the registered state: only DADOS blocks a new word.
  assign pronto_out  = (estado != DADOS);
  assign aceita      = valido_in & pronto_out;
  // Next word position; bit 0 is the next data bit to go on the line.
  assign desloc_prox = desloc >> 1;

`ifdef PARIDADE_IMPAR_EN
  assign bit_par = ~acc;
`else
  assign bit_par = acc;
`endif

  // Frame FSM with registered serial outputs. The accumulator holds the XOR
  // of every data bit already placed on bit_out, so the first bit is folded
  // in at load time (equivalent to clearing acc and accumulating bit 0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      desloc      <= '0;
      contador    <= '0;
      acc         <= 1'b0;
      bit_out     <= 1'b0;
      bit_valido  <= 1'b0;
      eh_paridade <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, PARIDADE: begin
          if (aceita) begin
            // Load a new word; bit 0 appears the cycle after this edge.
            estado      <= DADOS;
            desloc      <= dado_in;
            contador    <= '0;
            acc         <= dado_in[0];
            bit_out     <= dado_in[0];
            bit_valido  <= 1'b1;
            eh_paridade <= 1'b0;
          end else begin
            estado      <= OCIOSO;
            bit_out     <= 1'b0;
            bit_valido  <= 1'b0;
            eh_paridade <= 1'b0;
          end
        end
        DADOS: begin
          if (contador == ULTIMO) begin
            // Last data bit is on the line; next cycle carries parity.
            estado      <= PARIDADE;
            bit_out     <= bit_par;
            bit_valido  <= 1'b1;
            eh_paridade <= 1'b1;
          end else begin
            contador    <= contador + CW'(1);
            desloc      <= desloc_prox;
            acc         <= acc ^ desloc_prox[0];
            bit_out     <= desloc_prox[0];
            bit_valido  <= 1'b1;
            eh_paridade <= 1'b0;
          end
        end
        default: begin
          estado      <= OCIOSO;
          bit_out     <= 1'b0;
          bit_valido  <= 1'b0;
          eh_paridade <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador_paridade.sv
// Directed bench for serializador_paridade: a table of words with their
// hand-written serial streams and parities, plus sequences for back-to-back
// frames, ignored handshakes, mid-frame reset and a LARGURA=1 instance.
module tb_serializador_paridade;

`ifdef PARIDADE_IMPAR_EN
  localparam bit IMPAR = 1'b1;
`else
  localparam bit IMPAR = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] dado_in;
  logic       valido_in;
  logic       pronto_out, bit_out, bit_valido, eh_paridade;

  logic [0:0] dado1;
  logic       valido1;
  logic       pronto1, bit1, bv1, eh1;

  int n_chk;
  int n_fail;

  serializador_paridade #(.LARGURA(8)) dut8 (
    .clk(clk), .reset(reset), .dado_in(dado_in), .valido_in(valido_in),
    .pronto_out(pronto_out), .bit_out(bit_out), .bit_valido(bit_valido),
    .eh_paridade(eh_paridade)
  );

  serializador_paridade #(.LARGURA(1)) dut1 (
    .clk(clk), .reset(reset), .dado_in(dado1), .valido_in(valido1),
    .pronto_out(pronto1), .bit_out(bit1), .bit_valido(bv1),
    .eh_paridade(eh1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // serial: bits in emission order, leftmost ([7]) first; par: even parity
  typedef struct {
    logic [7:0] dado;
    logic [7:0] serial;
    logic       par;
  } vetor_t;

  task automatic chk(input string nome, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nome, act, exp, $time);
    end
  endtask

  task automatic chk_ocioso(input string nome);
    chk({nome, " bit_valido"}, bit_valido, 1'b0);
    chk({nome, " bit_out"}, bit_out, 1'b0);
    chk({nome, " eh_paridade"}, eh_paridade, 1'b0);
    chk({nome, " pronto_out"}, pronto_out, 1'b1);
  endtask

  // Entered at the negedge of cycle 1 of a frame; returns at the negedge of
  // the parity cycle. pulso_em: data cycle index for a stray 3C handshake.
  // manter: leave valido_in as the caller set it.
  task automatic chk_quadro(input string nome, input logic [7:0] serial,
                            input logic par, input int pulso_em, input bit manter);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s dado%0d valido", nome, i), bit_valido, 1'b1);
      chk($sformatf("%s dado%0d bit", nome, i), bit_out, serial[7-i]);
      chk($sformatf("%s dado%0d eh_par", nome, i), eh_paridade, 1'b0);
      chk($sformatf("%s dado%0d pronto", nome, i), pronto_out, 1'b0);
      if (i == pulso_em) begin
        valido_in = 1'b1;
        dado_in   = 8'h3C;
      end else if (!manter) begin
        valido_in = 1'b0;
      end
      @(negedge clk);
    end
    chk({nome, " par valido"}, bit_valido, 1'b1);
    chk({nome, " par bit"}, bit_out, par ^ IMPAR);
    chk({nome, " par eh_par"}, eh_paridade, 1'b1);
    chk({nome, " par pronto"}, pronto_out, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vetor_t tab [6];
    n_chk  = 0;
    n_fail = 0;
    tab[0] = '{dado: 8'hA5, serial: 8'b10100101, par: 1'b0};
    tab[1] = '{dado: 8'h07, serial: 8'b11100000, par: 1'b1};
    tab[2] = '{dado: 8'h00, serial: 8'b00000000, par: 1'b0};
    tab[3] = '{dado: 8'h96, serial: 8'b01101001, par: 1'b0};
    tab[4] = '{dado: 8'h80, serial: 8'b00000001, par: 1'b1};
    tab[5] = '{dado: 8'hFE, serial: 8'b01111111, par: 1'b1};

    dado_in = 8'h00; valido_in = 1'b0;
    dado1 = 1'b0; valido1 = 1'b0;
    reset = 1'b0;
    #1;
    chk_ocioso("reset");
    chk("reset L1 valido", bv1, 1'b0);
    chk("reset L1 pronto", pronto1, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_ocioso("apos reset");

    // Table of single frames separated by idle.
    for (int k = 0; k < 6; k++) begin
      dado_in = tab[k].dado; valido_in = 1'b1;
      @(negedge clk);
      chk_quadro($sformatf("tab%0d", k), tab[k].serial, tab[k].par, -1, 1'b0);
      @(negedge clk);
      chk_ocioso($sformatf("tab%0d fim", k));
    end

    // Back-to-back: FF then 01 with valido_in held high, no gap.
    dado_in = 8'hFF; valido_in = 1'b1;
    @(negedge clk);
    dado_in = 8'h01;
    chk_quadro("b2b FF", 8'b11111111, 1'b0, -1, 1'b1);
    @(negedge clk);
    valido_in = 1'b0;
    chk_quadro("b2b 01", 8'b10000000, 1'b1, -1, 1'b0);
    @(negedge clk);
    chk_ocioso("b2b fim");

    // Stray handshake during DADOS is ignored.
    dado_in = 8'hA5; valido_in = 1'b1;
    @(negedge clk);
    chk_quadro("pulso", 8'b10100101, 1'b0, 2, 1'b0);
    @(negedge clk);
    chk_ocioso("pulso fim");

    // Reset asserted while data bit 4 of A5 is on the line.
    dado_in = 8'hA5; valido_in = 1'b1;
    @(negedge clk);
    valido_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst meio valido antes", bit_valido, 1'b1);
    chk("rst meio pronto antes", pronto_out, 1'b0);
    reset = 1'b0;
    #1;
    chk_ocioso("rst meio");
    @(negedge clk);
    chk_ocioso("rst segurado");
    reset = 1'b1;
    @(negedge clk);
    chk_ocioso("rst liberado");
    dado_in = 8'h80; valido_in = 1'b1;
    @(negedge clk);
    chk_quadro("pos rst 80", 8'b00000001, 1'b1, -1, 1'b0);
    @(negedge clk);
    chk_ocioso("pos rst fim");

    // LARGURA=1: two-cycle frames.
    for (int k = 0; k < 2; k++) begin
      logic b;
      b = (k == 0) ? 1'b1 : 1'b0;
      dado1 = b; valido1 = 1'b1;
      @(negedge clk);
      valido1 = 1'b0;
      chk($sformatf("L1 w%0d c1 valido", k), bv1, 1'b1);
      chk($sformatf("L1 w%0d c1 bit", k), bit1, b);
      chk($sformatf("L1 w%0d c1 eh_par", k), eh1, 1'b0);
      chk($sformatf("L1 w%0d c1 pronto", k), pronto1, 1'b0);
      @(negedge clk);
      chk($sformatf("L1 w%0d c2 valido", k), bv1, 1'b1);
      chk($sformatf("L1 w%0d c2 bit", k), bit1, b ^ IMPAR);
      chk($sformatf("L1 w%0d c2 eh_par", k), eh1, 1'b1);
      chk($sformatf("L1 w%0d c2 pronto", k), pronto1, 1'b1);
      @(negedge clk);
      chk($sformatf("L1 w%0d fim valido", k), bv1, 1'b0);
      chk($sformatf("L1 w%0d fim bit", k), bit1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
